// File: rtl/kbd_pkg.sv
// kbd_pkg: shared types and constants for the PS/2 scancode decoder.
// Holds the prefix FSM state encoding, prefix bytes, modifier scancodes
// and the Hack keyboard codes for non-printable keys.
package kbd_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        EXT     = 2'd1,
        BRK     = 2'd2,
        EXT_BRK = 2'd3
    } state_t;

    localparam logic [7:0] PREFIX_EXT = 8'hE0;
    localparam logic [7:0] PREFIX_BRK = 8'hF0;

    localparam logic [7:0] SC_LSHIFT  = 8'h12;
    localparam logic [7:0] SC_RSHIFT  = 8'h59;
    localparam logic [7:0] SC_CAPS    = 8'h58;

    localparam logic [7:0] KEY_ENTER  = 8'd128;
    localparam logic [7:0] KEY_BKSP   = 8'd129;
    localparam logic [7:0] KEY_LEFT   = 8'd130;
    localparam logic [7:0] KEY_UP     = 8'd131;
    localparam logic [7:0] KEY_RIGHT  = 8'd132;
    localparam logic [7:0] KEY_DOWN   = 8'd133;
    localparam logic [7:0] KEY_HOME   = 8'd134;
    localparam logic [7:0] KEY_END    = 8'd135;
    localparam logic [7:0] KEY_PGUP   = 8'd136;
    localparam logic [7:0] KEY_PGDN   = 8'd137;
    localparam logic [7:0] KEY_INS    = 8'd138;
    localparam logic [7:0] KEY_DEL    = 8'd139;
    localparam logic [7:0] KEY_ESC    = 8'd140;
    localparam logic [7:0] KEY_F1     = 8'd141;
    localparam logic [7:0] KEY_F2     = 8'd142;
    localparam logic [7:0] KEY_F3     = 8'd143;
    localparam logic [7:0] KEY_F4     = 8'd144;
    localparam logic [7:0] KEY_F5     = 8'd145;
    localparam logic [7:0] KEY_F6     = 8'd146;
    localparam logic [7:0] KEY_F7     = 8'd147;
    localparam logic [7:0] KEY_F8     = 8'd148;
    localparam logic [7:0] KEY_F9     = 8'd149;
    localparam logic [7:0] KEY_F10    = 8'd150;
    localparam logic [7:0] KEY_F11    = 8'd151;
    localparam logic [7:0] KEY_F12    = 8'd152;

endpackage

// File: rtl/scancode_lut.sv
// scancode_lut: combinational translation of a set-2 scancode (with
// extended flag) into a Hack keyboard code. Result 0 means unknown key.
// Letters follow caps XOR shift; other printables follow shift only.
module scancode_lut
    import kbd_pkg::*;
(
    input  logic        ext,
    input  logic [7:0]  code,
    input  logic        shift,
    input  logic        caps,
    output logic [15:0] result
);

    logic [7:0] lo;
    logic [7:0] hi;
    logic       letter;
    logic [7:0] ch;

    // Lookup of the unshifted/shifted character for each known scancode
    always_comb begin
        lo     = '0;
        hi     = '0;
        letter = 1'b0;
        case ({ext, code})
            9'h01C: begin lo = "a"; letter = 1'b1; end
            9'h032: begin lo = "b"; letter = 1'b1; end
            9'h021: begin lo = "c"; letter = 1'b1; end
            9'h023: begin lo = "d"; letter = 1'b1; end
            9'h024: begin lo = "e"; letter = 1'b1; end
            9'h02B: begin lo = "f"; letter = 1'b1; end
            9'h034: begin lo = "g"; letter = 1'b1; end
            9'h033: begin lo = "h"; letter = 1'b1; end
            9'h043: begin lo = "i"; letter = 1'b1; end
            9'h03B: begin lo = "j"; letter = 1'b1; end
            9'h042: begin lo = "k"; letter = 1'b1; end
            9'h04B: begin lo = "l"; letter = 1'b1; end
            9'h03A: begin lo = "m"; letter = 1'b1; end
            9'h031: begin lo = "n"; letter = 1'b1; end
            9'h044: begin lo = "o"; letter = 1'b1; end
            9'h04D: begin lo = "p"; letter = 1'b1; end
            9'h015: begin lo = "q"; letter = 1'b1; end
            9'h02D: begin lo = "r"; letter = 1'b1; end
            9'h01B: begin lo = "s"; letter = 1'b1; end
            9'h02C: begin lo = "t"; letter = 1'b1; end
            9'h03C: begin lo = "u"; letter = 1'b1; end
            9'h02A: begin lo = "v"; letter = 1'b1; end
            9'h01D: begin lo = "w"; letter = 1'b1; end
            9'h022: begin lo = "x"; letter = 1'b1; end
            9'h035: begin lo = "y"; letter = 1'b1; end
            9'h01A: begin lo = "z"; letter = 1'b1; end
            9'h045: begin lo = "0"; hi = ")"; end
            9'h016: begin lo = "1"; hi = "!"; end
            9'h01E: begin lo = "2"; hi = "@"; end
            9'h026: begin lo = "3"; hi = "#"; end
            9'h025: begin lo = "4"; hi = "$"; end
            9'h02E: begin lo = "5"; hi = "%"; end
            9'h036: begin lo = "6"; hi = "^"; end
            9'h03D: begin lo = "7"; hi = "&"; end
            9'h03E: begin lo = "8"; hi = "*"; end
            9'h046: begin lo = "9"; hi = "("; end
            9'h029: begin lo = " "; hi = " "; end
            9'h00E: begin lo = 8'h60; hi = "~"; end
            9'h04E: begin lo = "-"; hi = "_"; end
            9'h055: begin lo = "="; hi = "+"; end
            9'h054: begin lo = "["; hi = "{"; end
            9'h05B: begin lo = "]"; hi = "}"; end
            9'h05D: begin lo = "\\"; hi = "|"; end
            9'h04C: begin lo = ";"; hi = ":"; end
            9'h052: begin lo = "'"; hi = "\""; end
            9'h041: begin lo = ","; hi = "<"; end
            9'h049: begin lo = "."; hi = ">"; end
            9'h04A: begin lo = "/"; hi = "?"; end
            // keypad digits (non-extended) always produce the digit
            9'h070: begin lo = "0"; hi = "0"; end
            9'h069: begin lo = "1"; hi = "1"; end
            9'h072: begin lo = "2"; hi = "2"; end
            9'h07A: begin lo = "3"; hi = "3"; end
            9'h06B: begin lo = "4"; hi = "4"; end
            9'h073: begin lo = "5"; hi = "5"; end
            9'h074: begin lo = "6"; hi = "6"; end
            9'h06C: begin lo = "7"; hi = "7"; end
            9'h075: begin lo = "8"; hi = "8"; end
            9'h07D: begin lo = "9"; hi = "9"; end
            9'h05A: begin lo = KEY_ENTER; hi = KEY_ENTER; end
            9'h066: begin lo = KEY_BKSP;  hi = KEY_BKSP;  end
            9'h076: begin lo = KEY_ESC;   hi = KEY_ESC;   end
            9'h005: begin lo = KEY_F1;    hi = KEY_F1;    end
            9'h006: begin lo = KEY_F2;    hi = KEY_F2;    end
            9'h004: begin lo = KEY_F3;    hi = KEY_F3;    end
            9'h00C: begin lo = KEY_F4;    hi = KEY_F4;    end
            9'h003: begin lo = KEY_F5;    hi = KEY_F5;    end
            9'h00B: begin lo = KEY_F6;    hi = KEY_F6;    end
            9'h083: begin lo = KEY_F7;    hi = KEY_F7;    end
            9'h00A: begin lo = KEY_F8;    hi = KEY_F8;    end
            9'h001: begin lo = KEY_F9;    hi = KEY_F9;    end
            9'h009: begin lo = KEY_F10;   hi = KEY_F10;   end
            9'h078: begin lo = KEY_F11;   hi = KEY_F11;   end
            9'h007: begin lo = KEY_F12;   hi = KEY_F12;   end
            9'h15A: begin lo = KEY_ENTER; hi = KEY_ENTER; end
            9'h16B: begin lo = KEY_LEFT;  hi = KEY_LEFT;  end
            9'h175: begin lo = KEY_UP;    hi = KEY_UP;    end
            9'h174: begin lo = KEY_RIGHT; hi = KEY_RIGHT; end
            9'h172: begin lo = KEY_DOWN;  hi = KEY_DOWN;  end
            9'h16C: begin lo = KEY_HOME;  hi = KEY_HOME;  end
            9'h169: begin lo = KEY_END;   hi = KEY_END;   end
            9'h17D: begin lo = KEY_PGUP;  hi = KEY_PGUP;  end
            9'h17A: begin lo = KEY_PGDN;  hi = KEY_PGDN;  end
            9'h170: begin lo = KEY_INS;   hi = KEY_INS;   end
            9'h171: begin lo = KEY_DEL;   hi = KEY_DEL;   end
            default: begin lo = '0; hi = '0; end
        endcase
    end

    // Case selection: letters use caps XOR shift, uppercase is lowercase - 0x20
    always_comb begin
        if (letter) begin
            ch = (shift ^ caps) ? (lo - 8'h20) : lo;
        end else begin
            ch = shift ? hi : lo;
        end
        result = {8'h00, ch};
    end

endmodule

// File: rtl/scancode_decoder.sv
// scancode_decoder: turns the PS/2 scancode byte stream into the Hack
// keyboard register value. Optional feature macro: CAPS_LOCK_EN adds a
// caps-lock toggle on scancode 0x58.
module scancode_decoder
    import kbd_pkg::*;
#(
    parameter int unsigned PREFIX_TIMEOUT = 50000
) (
    input  logic        clock50,
    input  logic        reset,
    input  logic [7:0]  ps2_code,
    input  logic        ps2_code_new,
    output logic [15:0] key_out,
    output logic        key_valid
);

    localparam int unsigned CW = $clog2(PREFIX_TIMEOUT + 1);

    state_t          state, state_nx;
    logic [CW-1:0]   cnt, cnt_nx;
    logic            done, brk, ext;
    logic [8:0]      held, held_nx;
    logic            lsh, lsh_nx, rsh, rsh_nx;
    logic            caps_lut;
    logic [15:0]     lut_result;
    logic [15:0]     key_nx;
    logic            is_held;

`ifdef CAPS_LOCK_EN
    logic            caps, caps_nx, caps_down, caps_down_nx;
    assign caps_lut = caps;
`else
    assign caps_lut = 1'b0;
`endif

    scancode_lut u_lut (
        .ext    (ext),
        .code   (ps2_code),
        .shift  (lsh | rsh),
        .caps   (caps_lut),
        .result (lut_result)
    );

    assign is_held = ({ext, ps2_code} == held);

    // Prefix state register
    always_ff @(posedge clock50) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Prefix FSM: byte classification, completion strobes and prefix timeout
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        done     = 1'b0;
        brk      = 1'b0;
        ext      = 1'b0;
        if (ps2_code_new) begin
            cnt_nx = '0;
            case (state)
                IDLE: begin
                    if (ps2_code == PREFIX_EXT)      state_nx = EXT;
                    else if (ps2_code == PREFIX_BRK) state_nx = BRK;
                    else                             done = 1'b1;
                end
                EXT: begin
                    if (ps2_code == PREFIX_BRK) begin
                        state_nx = EXT_BRK;
                    end else begin
                        done     = 1'b1;
                        ext      = 1'b1;
                        state_nx = IDLE;
                    end
                end
                BRK: begin
                    done     = 1'b1;
                    brk      = 1'b1;
                    state_nx = IDLE;
                end
                EXT_BRK: begin
                    done     = 1'b1;
                    brk      = 1'b1;
                    ext      = 1'b1;
                    state_nx = IDLE;
                end
                default: state_nx = IDLE;
            endcase
        end else if (state != IDLE) begin
            if (cnt == CW'(PREFIX_TIMEOUT - 1)) begin
                state_nx = IDLE;
                cnt_nx   = '0;
            end else begin
                cnt_nx = cnt + CW'(1);
            end
        end
    end

    // Key/modifier update for a completed make or break
    always_comb begin
        key_nx  = key_out;
        held_nx = held;
        lsh_nx  = lsh;
        rsh_nx  = rsh;
`ifdef CAPS_LOCK_EN
        caps_nx      = caps;
        caps_down_nx = caps_down;
`endif
        if (done) begin
            if (!ext && ps2_code == SC_LSHIFT) begin
                lsh_nx = !brk;
            end else if (!ext && ps2_code == SC_RSHIFT) begin
                rsh_nx = !brk;
`ifdef CAPS_LOCK_EN
            end else if (!ext && ps2_code == SC_CAPS) begin
                // caps_down suppresses re-toggling on typematic repeats
                if (brk) begin
                    caps_down_nx = 1'b0;
                end else if (!caps_down) begin
                    caps_nx      = !caps;
                    caps_down_nx = 1'b1;
                end
`endif
            end else if (brk) begin
                if (is_held) key_nx = '0;
            end else if (lut_result != '0 && !(is_held && key_out != '0)) begin
                key_nx  = lut_result;
                held_nx = {ext, ps2_code};
            end
        end
    end

    // Datapath registers; key_valid flags a change of key_out
    always_ff @(posedge clock50) begin
        if (reset) begin
            cnt       <= '0;
            key_out   <= '0;
            key_valid <= 1'b0;
            held      <= '0;
            lsh       <= 1'b0;
            rsh       <= 1'b0;
`ifdef CAPS_LOCK_EN
            caps      <= 1'b0;
            caps_down <= 1'b0;
`endif
        end else begin
            cnt       <= cnt_nx;
            key_out   <= key_nx;
            key_valid <= (key_nx != key_out);
            held      <= held_nx;
            lsh       <= lsh_nx;
            rsh       <= rsh_nx;
`ifdef CAPS_LOCK_EN
            caps      <= caps_nx;
            caps_down <= caps_down_nx;
`endif
        end
    end

endmodule

// File: tb/tb_scancode_decoder.sv
// tb_scancode_decoder: directed scancode sequences; expected key_out values
// for each key_valid pulse are queued at stimulus time and checked by an
// independent monitor, together with the exact pulse cycle.
module tb_scancode_decoder;

    localparam int unsigned TMO = 20;

    logic        clock50 = 1'b0;
    logic        reset;
    logic [7:0]  ps2_code;
    logic        ps2_code_new;
    logic [15:0] key_out;
    logic        key_valid;

    typedef struct {
        logic [15:0] key;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    int   cyc   = 0;
    int   n_vec = 0;
    int   n_err = 0;

    scancode_decoder #(.PREFIX_TIMEOUT(TMO)) dut (
        .clock50      (clock50),
        .reset        (reset),
        .ps2_code     (ps2_code),
        .ps2_code_new (ps2_code_new),
        .key_out      (key_out),
        .key_valid    (key_valid)
    );

    always #5 clock50 = ~clock50;

    always @(posedge clock50) cyc <= cyc + 1;

    // Monitor: every key_valid pulse must match the oldest queued expectation
    always @(negedge clock50) begin
        if (key_valid) begin
            n_vec++;
            if (sb.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_pulse: key_out=%h at cycle %0d, no pulse required", key_out, cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (key_out !== e.key || cyc != e.cyc) begin
                    n_err++;
                    $display("FAIL pulse: key_out=%h at cycle %0d, required %h at cycle %0d",
                             key_out, cyc, e.key, e.cyc);
                end
            end
        end
    end

    // One strobed byte; idle cycles carry a prefix byte on ps2_code to prove it is ignored
    task automatic send(input logic [7:0] b, input bit pulse, input logic [15:0] k);
        exp_t e;
        @(negedge clock50);
        ps2_code     = b;
        ps2_code_new = 1'b1;
        if (pulse) begin
            e.key = k;
            e.cyc = cyc + 1;
            sb.push_back(e);
        end
        @(negedge clock50);
        ps2_code_new = 1'b0;
        ps2_code     = 8'hF0;
    endtask

    task automatic check(input string name, input logic [15:0] exp);
        repeat (2) @(negedge clock50);
        n_vec++;
        if (key_out !== exp || sb.size() != 0) begin
            n_err++;
            $display("FAIL %s: key_out=%h pending_pulses=%0d, required %h pending_pulses=0",
                     name, key_out, sb.size(), exp);
            sb.delete();
        end
    endtask

    task automatic pulse_reset(input bit with_byte);
        @(negedge clock50);
        reset = 1'b1;
        if (with_byte) begin
            ps2_code     = 8'h1C;
            ps2_code_new = 1'b1;
        end
        @(negedge clock50);
        reset        = 1'b0;
        ps2_code_new = 1'b0;
        ps2_code     = 8'hF0;
    endtask

    initial begin
        reset        = 1'b1;
        ps2_code     = 8'h00;
        ps2_code_new = 1'b0;
        repeat (3) @(negedge clock50);
        n_vec++;
        if (key_out !== 16'h0000 || key_valid !== 1'b0) begin
            n_err++;
            $display("FAIL reset_state: key_out=%h key_valid=%b, required 0000 0", key_out, key_valid);
        end
        reset = 1'b0;

        // plain make / break
        send(8'h1C, 1, 16'h0061);  check("make_a", 16'h0061);
        send(8'hF0, 0, 0);  send(8'h1C, 1, 16'h0000);  check("break_a", 16'h0000);

        // shift sampled at make time only
        send(8'h12, 0, 0);  send(8'h1C, 1, 16'h0041);  check("shift_A", 16'h0041);
        send(8'hF0, 0, 0);  send(8'h12, 0, 0);         check("shift_release", 16'h0041);
        send(8'hF0, 0, 0);  send(8'h1C, 1, 16'h0000);
        send(8'h59, 0, 0);  send(8'h16, 1, 16'h0021);  check("rshift_bang", 16'h0021);
        send(8'hF0, 0, 0);  send(8'h59, 0, 0);
        send(8'hF0, 0, 0);  send(8'h16, 1, 16'h0000);  check("break_1", 16'h0000);

        // extended vs keypad
        send(8'hE0, 0, 0);  send(8'h75, 1, 16'd131);   check("ext_up", 16'd131);
        send(8'hE0, 0, 0);  send(8'hF0, 0, 0);  send(8'h75, 1, 16'h0000);
        check("ext_break", 16'h0000);
        send(8'h75, 1, 16'h0038);                      check("keypad_8", 16'h0038);

        // non-matching break leaves key_out
        send(8'h1C, 1, 16'h0061);  send(8'h32, 1, 16'h0062);
        send(8'hF0, 0, 0);  send(8'h1C, 0, 0);         check("stale_break", 16'h0062);
        send(8'hF0, 0, 0);  send(8'h32, 1, 16'h0000);

        // unknown scancode and special keys
        send(8'h58, 0, 0);                             check("unknown", 16'h0000);
        send(8'h5A, 1, 16'd128);  send(8'h76, 1, 16'd140);
        send(8'h05, 1, 16'd141);  send(8'h07, 1, 16'd152);
        check("f12", 16'd152);
        send(8'hF0, 0, 0);  send(8'h07, 1, 16'h0000);

        // typematic repeat
        send(8'h1C, 1, 16'h0061);  send(8'h1C, 0, 0);  send(8'h1C, 0, 0);
        check("typematic", 16'h0061);
        send(8'hF0, 0, 0);  send(8'h1C, 1, 16'h0000);

        // prefix timeout: exactly TMO idle cycles abandons F0
        send(8'hF0, 0, 0);
        repeat (TMO - 1) @(negedge clock50);
        send(8'h1C, 1, 16'h0061);                      check("timeout_make", 16'h0061);
        // one cycle short of the timeout still completes the break
        send(8'hF0, 0, 0);
        repeat (TMO - 2) @(negedge clock50);
        send(8'h1C, 1, 16'h0000);                      check("timeout_edge_break", 16'h0000);

        // reset mid-sequence discards the E0 prefix
        send(8'hE0, 0, 0);
        pulse_reset(0);
        send(8'h75, 1, 16'h0038);                      check("reset_mid_seq", 16'h0038);
        send(8'h1C, 1, 16'h0061);  send(8'h1C, 0, 0);  send(8'h1C, 0, 0);
        check("one_pulse", 16'h0061);

        // reset wins over a coincident strobe
        pulse_reset(1);
        check("reset_priority", 16'h0000);

        repeat (3) @(negedge clock50);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
